decoder_scan_ctrl: RTL

- Sequential driver that sits directly upstream of `generate_decoder` and feeds its `in` and `select` inputs.
- Accepts a 4-bit pattern through a valid/ready handshake, then steps `select` through 00, 01, 10, 11, holding each step for `DWELL` cycles.
- On each step it drives `in` with the matching pattern bit.
- It pulses `done` when the scan completes and supports abort.

---
 rtl/decoder_pkg.sv | 13 +
 rtl/decoder_scan_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/decoder_pkg.sv
// Shared types and sizes for the decoder scan driver and its downstream decoder.
package decoder_pkg;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned NCH   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_scan_ctrl.sv
// Steps a 2-bit decoder select through all four channels, driving the matching
// pattern bit on 'in' for DWELL cycles each; pulses done on normal completion.
module decoder_scan_ctrl
  import decoder_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  input  logic [NCH-1:0]   pattern,
  input  logic             abort,
  output logic             start_ready,
  output logic             in,
  output logic [SEL_W-1:0] select,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NCH - 1);

  state_t           state_q, state_d;
  logic [NCH-1:0]   pat_q, pat_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DW-1:0]    dwell_q, dwell_d;

  logic             start_ready_d;
  logic             in_d;
  logic [SEL_W-1:0] select_d;
  logic             busy_d;
  logic             done_d;

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    sel_d         = sel_q;
    dwell_d       = dwell_q;
    start_ready_d = 1'b0;
    in_d          = 1'b0;
    select_d      = '0;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          pat_d   = pattern;
          sel_d   = '0;
          dwell_d = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (abort) begin
          sel_d   = '0;
          dwell_d = '0;
          state_d = IDLE;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (sel_q == SEL_LAST) begin
            sel_d   = '0;
            state_d = FINISH;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      IDLE:    start_ready_d = 1'b1;
      DRIVE: begin
        in_d     = pat_d[sel_d];
        select_d = sel_d;
        busy_d   = 1'b1;
      end
      FINISH:  done_d = 1'b1;
      default: start_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      sel_q       <= '0;
      dwell_q     <= '0;
      start_ready <= 1'b1;
      in          <= 1'b0;
      select      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      sel_q       <= sel_d;
      dwell_q     <= dwell_d;
      start_ready <= start_ready_d;
      in          <= in_d;
      select      <= select_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule
